cam_table_mgr: RTL and testbench
================================

Name: cam_table_mgr

Overview:
Upstream command stage for the block-RAM CAM. It accepts insert/delete-by-key requests and looks the key up through the CAM compare port. It allocates or frees a CAM slot from an internal valid bitmap, then drives the CAM write port with a write_enable/write_busy handshake. It returns one status response per request and tracks the table occupancy.

Parameters:
DATA_WIDTH, 64, key width; must equal the CAM's DATA_WIDTH
ADDR_WIDTH, 5, log2 of the number of CAM entries; RAM_DEPTH = 2**ADDR_WIDTH

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  request accepted when valid&ready at posedge
req_op  in  1  0=insert, 1=delete
req_key  in  DATA_WIDTH  key
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed when valid&ready
rsp_status  out  2  0=OK, 1=FULL, 2=NOT_FOUND, 3=EXISTS
rsp_addr  out  ADDR_WIDTH  slot written, freed, or already holding the key
entry_count  out  ADDR_WIDTH+1  number of valid slots
cam_write_addr  out  ADDR_WIDTH  to CAM write_addr
cam_write_data  out  DATA_WIDTH  to CAM write_data
cam_write_delete  out  1  to CAM write_delete
cam_write_enable  out  1  to CAM write_enable (one-cycle pulse)
cam_write_busy  in  1  from CAM write_busy
cam_compare_data  out  DATA_WIDTH  to CAM compare_data
cam_match  in  1  from CAM match
cam_match_addr  in  ADDR_WIDTH  from CAM match_addr

Behaviour:
- Reset (async, rst=1):
  - Outputs: req_ready=0, rsp_valid=0, rsp_status=0, rsp_addr=0, entry_count=0, cam_write_enable=0, cam_write_delete=0, cam_write_addr=0, cam_write_data=0, cam_compare_data=0.
  - State: valid bitmap all 0; state=IDLE.
  - Mid-operation reset aborts the request with no response. The CAM's own reset re-initialises it.
- Registered outputs: every output is a flop output. cam_compare_data, cam_write_data and cam_write_addr hold their values until the next request.
- FSM states: IDLE, LOOKUP, DECIDE, ISSUE, WAIT_START, WAIT_DONE, RESP.
- IDLE:
  - req_ready = (state==IDLE) & ~cam_write_busy, so nothing is accepted while the CAM initialises.
  - On accept: latch op and key, set cam_compare_data=key, go to LOOKUP.
- LOOKUP: one wait cycle for the CAM read (negedge-clocked compare RAM); go to DECIDE.
- DECIDE: sample cam_match and cam_match_addr.
  - Insert, match=1 -> rsp EXISTS, addr=match_addr; go to RESP with no write.
  - Insert, no match, bitmap full -> rsp FULL, addr=0; go to RESP.
  - Insert, no match, free slot -> slot = lowest-index 0 bit of the bitmap; cam_write_addr=slot, cam_write_data=key, cam_write_delete=0; go to ISSUE.
  - Delete, match=0 -> rsp NOT_FOUND, addr=0; go to RESP.
  - Delete, match=1 -> cam_write_addr=match_addr, cam_write_delete=1; go to ISSUE.
- ISSUE: if cam_write_busy=0, assert cam_write_enable for exactly one cycle and go to WAIT_START; otherwise hold in ISSUE.
- WAIT_START: wait for cam_write_busy=1, then go to WAIT_DONE. Guard: if busy is not seen within 2 cycles, proceed to WAIT_DONE anyway.
- WAIT_DONE: wait for cam_write_busy=0.
  - Then update the bitmap: insert sets the bit and increments entry_count; delete clears the bit and decrements entry_count.
  - rsp_status=OK, rsp_addr=slot; go to RESP.
- RESP: rsp_valid=1, with fields stable until rsp_ready. On handshake, rsp_valid=0 and go to IDLE. A new request is accepted no earlier than the cycle after the handshake.
- Occupancy bounds: entry_count never exceeds RAM_DEPTH and never underflows. Full means bitmap all ones; entry_count==RAM_DEPTH then.
- Minimum latency: accept to rsp_valid is 3 cycles for no-write outcomes. With a write it is 5 cycles plus the CAM busy duration.
- Ordering: one request in flight; responses are returned strictly in request order.

Test Plan:
1. Hold cam_write_busy=1 after reset, assert req_valid -> req_ready stays 0. Release busy -> accepted next cycle.
2. Insert 0x1234 into empty table -> one cam_write_enable pulse with addr=0, delete=0, data=0x1234. Response OK, addr=0, entry_count=1.
3. Insert 0x1234 again (CAM model reports match at addr 0) -> no write pulse. Response EXISTS, addr=0.
4. Fill all 32 slots, then insert a new key -> response FULL, addr=0, no write, entry_count=32.
5. Delete a key matching at addr 7 -> write pulse with addr=7, delete=1. Response OK, addr=7; count decrements. A following insert of a new key reuses slot 7.
6. Delete an absent key -> NOT_FOUND. Then test backpressure and reset: hold rsp_ready=0 for 10 cycles -> rsp fields stable; assert rst in WAIT_DONE -> all outputs 0 immediately and entry_count=0.

Source files
------------

// File: rtl/cam_table_mgr.sv
// Command front-end for the block-RAM CAM: insert/delete by key, slot allocation
// from a valid bitmap, CAM write handshake, one status response per request.
module cam_table_mgr #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_op,
  input  logic [DATA_WIDTH-1:0] req_key,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [1:0]            rsp_status,
  output logic [ADDR_WIDTH-1:0] rsp_addr,
  output logic [ADDR_WIDTH:0]   entry_count,
  output logic [ADDR_WIDTH-1:0] cam_write_addr,
  output logic [DATA_WIDTH-1:0] cam_write_data,
  output logic                  cam_write_delete,
  output logic                  cam_write_enable,
  input  logic                  cam_write_busy,
  output logic [DATA_WIDTH-1:0] cam_compare_data,
  input  logic                  cam_match,
  input  logic [ADDR_WIDTH-1:0] cam_match_addr
);
  localparam int RAM_DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] CNT_ONE = 1;
  localparam logic [1:0] ST_OK = 2'd0, ST_FULL = 2'd1, ST_NF = 2'd2, ST_EXISTS = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_DECIDE, S_ISSUE, S_WAIT_START, S_WAIT_DONE, S_RESP
  } state_e;

  state_e                  state_q, state_d;
  logic                    op_q, op_d;
  logic [RAM_DEPTH-1:0]    bitmap_q, bitmap_d;
  logic [ADDR_WIDTH:0]     cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   wa_q, wa_d;
  logic [DATA_WIDTH-1:0]   wd_q, wd_d;
  logic [DATA_WIDTH-1:0]   cmp_q, cmp_d;
  logic                    wdel_q, wdel_d;
  logic                    we_q, we_d;
  logic                    rdy_q, rdy_d;
  logic                    rv_q, rv_d;
  logic [1:0]              st_q, st_d;
  logic [ADDR_WIDTH-1:0]   ra_q, ra_d;
  logic                    guard_q, guard_d;
  logic [ADDR_WIDTH-1:0]   free_slot;
  logic                    full;
  logic                    accept;

  assign full   = &bitmap_q;
  assign accept = req_valid && rdy_q;

  // Lowest-index free slot; scanning downward lets the lowest index win.
  always_comb begin
    free_slot = '0;
    for (int i = RAM_DEPTH-1; i >= 0; i--)
      if (!bitmap_q[i]) free_slot = i[ADDR_WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= 1'b0;
      bitmap_q <= '0;
      cnt_q    <= '0;
      wa_q     <= '0;
      wd_q     <= '0;
      cmp_q    <= '0;
      wdel_q   <= 1'b0;
      we_q     <= 1'b0;
      rdy_q    <= 1'b0;
      rv_q     <= 1'b0;
      st_q     <= '0;
      ra_q     <= '0;
      guard_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      bitmap_q <= bitmap_d;
      cnt_q    <= cnt_d;
      wa_q     <= wa_d;
      wd_q     <= wd_d;
      cmp_q    <= cmp_d;
      wdel_q   <= wdel_d;
      we_q     <= we_d;
      rdy_q    <= rdy_d;
      rv_q     <= rv_d;
      st_q     <= st_d;
      ra_q     <= ra_d;
      guard_q  <= guard_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:       if (accept) state_d = S_LOOKUP;
      S_LOOKUP:     state_d = S_DECIDE;
      S_DECIDE:     state_d = (op_q ? cam_match : (!cam_match && !full)) ? S_ISSUE : S_RESP;
      S_ISSUE:      if (!cam_write_busy) state_d = S_WAIT_START;
      // Busy may never be observed if the CAM finishes instantly; give up after two cycles.
      S_WAIT_START: if (cam_write_busy || guard_q) state_d = S_WAIT_DONE;
      S_WAIT_DONE:  if (!cam_write_busy) state_d = S_RESP;
      S_RESP:       if (rsp_ready) state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  always_comb begin
    op_d     = op_q;
    bitmap_d = bitmap_q;
    cnt_d    = cnt_q;
    wa_d     = wa_q;
    wd_d     = wd_q;
    cmp_d    = cmp_q;
    wdel_d   = wdel_q;
    we_d     = 1'b0;
    rdy_d    = (state_d == S_IDLE) && !cam_write_busy;
    rv_d     = rv_q;
    st_d     = st_q;
    ra_d     = ra_q;
    guard_d  = guard_q;
    unique case (state_q)
      S_IDLE: if (accept) begin
        op_d  = req_op;
        cmp_d = req_key;
      end
      S_DECIDE: begin
        if (!op_q) begin
          if (cam_match) begin
            st_d = ST_EXISTS; ra_d = cam_match_addr; rv_d = 1'b1;
          end else if (full) begin
            st_d = ST_FULL; ra_d = '0; rv_d = 1'b1;
          end else begin
            wa_d = free_slot; wd_d = cmp_q; wdel_d = 1'b0;
          end
        end else begin
          if (!cam_match) begin
            st_d = ST_NF; ra_d = '0; rv_d = 1'b1;
          end else begin
            wa_d = cam_match_addr; wdel_d = 1'b1;
          end
        end
      end
      S_ISSUE: if (!cam_write_busy) begin
        we_d    = 1'b1;
        guard_d = 1'b0;
      end
      S_WAIT_START: guard_d = 1'b1;
      S_WAIT_DONE: if (!cam_write_busy) begin
        // Bit checks keep the count consistent with the bitmap even on a stale CAM hit.
        if (wdel_q) begin
          if (bitmap_q[wa_q]) cnt_d = cnt_q - CNT_ONE;
          bitmap_d[wa_q] = 1'b0;
        end else begin
          if (!bitmap_q[wa_q]) cnt_d = cnt_q + CNT_ONE;
          bitmap_d[wa_q] = 1'b1;
        end
        st_d = ST_OK;
        ra_d = wa_q;
        rv_d = 1'b1;
      end
      S_RESP: if (rsp_ready) rv_d = 1'b0;
      default: ;
    endcase
  end

  assign req_ready        = rdy_q;
  assign rsp_valid        = rv_q;
  assign rsp_status       = st_q;
  assign rsp_addr         = ra_q;
  assign entry_count      = cnt_q;
  assign cam_write_addr   = wa_q;
  assign cam_write_data   = wd_q;
  assign cam_write_delete = wdel_q;
  assign cam_write_enable = we_q;
  assign cam_compare_data = cmp_q;
endmodule

// File: tb/tb_cam_table_mgr.sv
// Directed bench for cam_table_mgr: behavioural CAM, reference table model,
// per-response and per-write-pulse comparisons plus literal spot checks.
module tb_cam_table_mgr;
  logic        clk, rst;
  logic        req_valid, req_ready, req_op;
  logic [63:0] req_key;
  logic        rsp_valid, rsp_ready;
  logic [1:0]  rsp_status;
  logic [4:0]  rsp_addr;
  logic [5:0]  entry_count;
  logic [4:0]  cam_write_addr;
  logic [63:0] cam_write_data;
  logic        cam_write_delete, cam_write_enable, cam_write_busy;
  logic [63:0] cam_compare_data;
  logic        cam_match;
  logic [4:0]  cam_match_addr;

  cam_table_mgr #(.DATA_WIDTH(64), .ADDR_WIDTH(5)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_key(req_key),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status),
    .rsp_addr(rsp_addr), .entry_count(entry_count),
    .cam_write_addr(cam_write_addr), .cam_write_data(cam_write_data),
    .cam_write_delete(cam_write_delete), .cam_write_enable(cam_write_enable),
    .cam_write_busy(cam_write_busy), .cam_compare_data(cam_compare_data),
    .cam_match(cam_match), .cam_match_addr(cam_match_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural CAM ----------------
  logic [63:0] ck [32];
  bit          cv [32];
  int          bcnt;
  logic        force_busy;
  logic [4:0]  pa;
  logic [63:0] pd;
  logic        pdel;

  assign cam_write_busy = force_busy | (bcnt != 0);

  always_comb begin
    cam_match = 1'b0;
    cam_match_addr = '0;
    for (int i = 31; i >= 0; i--)
      if (cv[i] && ck[i] == cam_compare_data) begin
        cam_match = 1'b1;
        cam_match_addr = i[4:0];
      end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) cv[i] <= 1'b0;
      bcnt <= 0;
    end else if (bcnt != 0) begin
      bcnt <= bcnt - 1;
      if (bcnt == 1) begin
        if (pdel) cv[pa] <= 1'b0;
        else begin ck[pa] <= pd; cv[pa] <= 1'b1; end
      end
    end else if (cam_write_enable && !force_busy) begin
      bcnt <= 3;
      pa   <= cam_write_addr;
      pd   <= cam_write_data;
      pdel <= cam_write_delete;
    end
  end

  // ---------------- reference table model ----------------
  typedef struct { logic [1:0] st; logic [4:0] addr; int cnt; } rsp_t;
  typedef struct { logic [4:0] addr; logic [63:0] data; logic del; } wr_t;
  rsp_t        exp_q [$];
  wr_t         wexp_q [$];
  logic [63:0] m_key [32];
  bit          m_vld [32];
  int          m_cnt;

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) m_vld[i] = 1'b0;
    m_cnt = 0;
    exp_q.delete();
    wexp_q.delete();
  endfunction

  function automatic void model_push(input logic op, input logic [63:0] key);
    int hit = -1;
    int fr = -1;
    rsp_t r;
    wr_t w;
    for (int i = 0; i < 32; i++) begin
      if (m_vld[i] && m_key[i] == key && hit < 0) hit = i;
      if (!m_vld[i] && fr < 0) fr = i;
    end
    r.addr = 5'd0;
    if (!op) begin
      if (hit >= 0) begin r.st = 2'd3; r.addr = hit[4:0]; end
      else if (fr < 0) r.st = 2'd1;
      else begin
        m_vld[fr] = 1'b1; m_key[fr] = key; m_cnt++;
        r.st = 2'd0; r.addr = fr[4:0];
        w.addr = fr[4:0]; w.data = key; w.del = 1'b0;
        wexp_q.push_back(w);
      end
    end else begin
      if (hit < 0) r.st = 2'd2;
      else begin
        m_vld[hit] = 1'b0; m_cnt--;
        r.st = 2'd0; r.addr = hit[4:0];
        w.addr = hit[4:0]; w.data = '0; w.del = 1'b1;
        wexp_q.push_back(w);
      end
    end
    r.cnt = m_cnt;
    exp_q.push_back(r);
  endfunction

  // ---------------- compare processes ----------------
  logic [1:0] last_st;
  logic [4:0] last_addr;
  logic [5:0] last_cnt;
  logic       prev_we;

  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) chk("unexpected_rsp", 64'(rsp_valid), 64'd0);
      else begin
        rsp_t e;
        e = exp_q.pop_front();
        chk("rsp_status", 64'(rsp_status), 64'(e.st));
        chk("rsp_addr", 64'(rsp_addr), 64'(e.addr));
        chk("entry_count", 64'(entry_count), 64'(e.cnt));
      end
      last_st = rsp_status; last_addr = rsp_addr; last_cnt = entry_count;
    end
  end

  always @(negedge clk) begin
    if (!rst && cam_write_enable) begin
      chk("we_pulse_width", 64'(prev_we), 64'd0);
      if (wexp_q.size() == 0) chk("unexpected_write", 64'(cam_write_enable), 64'd0);
      else begin
        wr_t w;
        w = wexp_q.pop_front();
        chk("wr_addr", 64'(cam_write_addr), 64'(w.addr));
        chk("wr_delete", 64'(cam_write_delete), 64'(w.del));
        if (!w.del) chk("wr_data", cam_write_data, w.data);
      end
    end
    prev_we = rst ? 1'b0 : cam_write_enable;
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_req(input logic op, input logic [63:0] key, output bit ok);
    int n = 0;
    model_push(op, key);
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_key = key;
    while (!req_ready && n < 100) begin @(negedge clk); n++; end
    ok = req_ready;
    if (!ok) chk("req_accept_timeout", 64'(req_ready), 64'd1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int hold, output int lat);
    lat = 1;
    while (!rsp_valid && lat < 200) begin @(negedge clk); lat++; end
    if (!rsp_valid) begin
      chk("rsp_timeout", 64'(rsp_valid), 64'd1);
      rsp_ready = 1'b1;
      return;
    end
    if (hold > 0) begin
      logic [1:0] s0; logic [4:0] a0;
      s0 = rsp_status; a0 = rsp_addr;
      for (int k = 0; k < hold; k++) begin
        @(negedge clk);
        chk("bp_valid", 64'(rsp_valid), 64'd1);
        chk("bp_status", 64'(rsp_status), 64'(s0));
        chk("bp_addr", 64'(rsp_addr), 64'(a0));
      end
      @(posedge clk); #1 rsp_ready = 1'b1;
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic do_req(input logic op, input logic [63:0] key, input int hold, output int lat);
    bit ok;
    lat = 0;
    if (hold > 0) rsp_ready = 1'b0;
    send_req(op, key, ok);
    if (ok) wait_rsp(hold, lat);
    else rsp_ready = 1'b1;
  endtask

  task automatic lit(input string nm, input logic [1:0] s, input logic [4:0] a, input logic [5:0] c);
    chk({nm, "_status"}, 64'(last_st), 64'(s));
    chk({nm, "_addr"}, 64'(last_addr), 64'(a));
    chk({nm, "_count"}, 64'(last_cnt), 64'(c));
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_req_ready"}, 64'(req_ready), 64'd0);
    chk({nm, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    chk({nm, "_rsp_status"}, 64'(rsp_status), 64'd0);
    chk({nm, "_rsp_addr"}, 64'(rsp_addr), 64'd0);
    chk({nm, "_entry_count"}, 64'(entry_count), 64'd0);
    chk({nm, "_we"}, 64'(cam_write_enable), 64'd0);
    chk({nm, "_wdel"}, 64'(cam_write_delete), 64'd0);
    chk({nm, "_waddr"}, 64'(cam_write_addr), 64'd0);
    chk({nm, "_wdata"}, cam_write_data, 64'd0);
    chk({nm, "_cmp"}, cam_compare_data, 64'd0);
  endtask

  initial begin
    int lat;
    bit ok;
    int n;
    rst = 1'b0; req_valid = 1'b0; req_op = 1'b0; req_key = '0;
    rsp_ready = 1'b1; force_busy = 1'b1; prev_we = 1'b0;
    model_reset();
    #2 rst = 1'b1;
    #1 chk_all_zero("reset");
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // CAM still initialising: no accept while busy
    model_push(1'b0, 64'h1234);
    req_valid = 1'b1; req_op = 1'b0; req_key = 64'h1234;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("ready_while_busy", 64'(req_ready), 64'd0);
    end
    force_busy = 1'b0;
    @(negedge clk);
    chk("ready_after_busy", 64'(req_ready), 64'd1);
    @(negedge clk);
    req_valid = 1'b0;
    wait_rsp(0, lat);
    lit("first_insert", 2'd0, 5'd0, 6'd1);

    do_req(1'b0, 64'h1234, 0, lat);
    lit("dup_insert", 2'd3, 5'd0, 6'd1);
    chk("no_write_latency", 64'(lat), 64'd3);

    for (int i = 1; i < 32; i++) do_req(1'b0, 64'h1000 + 64'(i), 0, lat);
    lit("fill", 2'd0, 5'd31, 6'd32);

    do_req(1'b0, 64'h9999, 0, lat);
    lit("full", 2'd1, 5'd0, 6'd32);

    do_req(1'b1, 64'h1007, 0, lat);
    lit("delete7", 2'd0, 5'd7, 6'd31);

    do_req(1'b0, 64'h7777, 0, lat);
    lit("reuse7", 2'd0, 5'd7, 6'd32);

    do_req(1'b1, 64'hDEAD, 10, lat);
    lit("not_found", 2'd2, 5'd0, 6'd32);

    // abort a delete while the CAM write is in progress
    send_req(1'b1, 64'h1010, ok);
    n = 0;
    while (!cam_write_busy && n < 50) begin @(negedge clk); n++; end
    chk("busy_seen", 64'(cam_write_busy), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    #1 chk_all_zero("midop_reset");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    do_req(1'b0, 64'hBEEF, 0, lat);
    lit("after_reset", 2'd0, 5'd0, 6'd1);

    chk("pending_rsp", 64'(exp_q.size()), 64'd0);
    chk("pending_wr", 64'(wexp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
